// File: rtl/uart_axil_pkg.sv
// Shared types and constants for the UART-to-AXI-Lite loader.
package uart_axil_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} ld_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // err vector bit positions: {overrun, rx_error, bus_error}
  localparam int ERR_BUS = 0;
  localparam int ERR_RX  = 1;
  localparam int ERR_OVR = 2;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchroniser, mid-bit sampling, 8N1 framing
// (8E1 when UART_PARITY_EN is defined).
module uart_rx
  import uart_axil_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  // [0],[1] synchroniser; [2] previous synchronised value for edge detect
  logic [2:0]    sync_q, sync_d;
  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          rx_s, rx_prev, frame_ok;
`ifdef UART_PARITY_EN
  logic          par_ok_q, par_ok_d;
`endif

  assign rx_s    = sync_q[1];
  assign rx_prev = sync_q[2];

`ifdef UART_PARITY_EN
  assign frame_ok = rx_s && par_ok_q;
`else
  assign frame_ok = rx_s;
`endif

  always_comb begin
    sync_d  = {sync_q[1:0], rx};
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef UART_PARITY_EN
    par_ok_d = par_ok_q;
`endif
    case (state_q)
      // A falling edge is required, so a line held low after a bad
      // stop bit does not retrigger a frame.
      RX_IDLE: if (rx_prev && !rx_s) begin
        state_d = RX_START;
        cnt_d   = '0;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = RX_PAR;
`else
            state_d = RX_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_PARITY_EN
      RX_PAR: begin
        if (cnt_q == FULL) begin
          cnt_d    = '0;
          par_ok_d = (rx_s == ^shreg_q);
          state_d  = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      RX_STOP: begin
        if (cnt_q == FULL) begin
          state_d = RX_IDLE;
          if (frame_ok) valid_d = 1'b1;
          else          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q  <= 3'b111;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef UART_PARITY_EN
      par_ok_q <= 1'b0;
`endif
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef UART_PARITY_EN
      par_ok_q <= par_ok_d;
`endif
    end
  end

  assign data_o  = shreg_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: rtl/uart_axil_loader.sv
// Streams UART bytes into little-endian words and writes them over AXI-Lite.
// Define UART_PARITY_EN to expect an even-parity bit in each UART frame.
module uart_axil_loader
  import uart_axil_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUDRATE    = 9600,
  parameter int BASE_ADDR   = 0,
  parameter int WORD_COUNT  = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    rx,
  input  logic                    start,
  output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic [2:0]              m_axil_awprot,
  output logic                    m_axil_awvalid,
  input  logic                    m_axil_awready,
  output logic [DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                    m_axil_wvalid,
  input  logic                    m_axil_wready,
  input  logic [1:0]              m_axil_bresp,
  input  logic                    m_axil_bvalid,
  output logic                    m_axil_bready,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              err
);

  localparam int BPW          = DATA_WIDTH / 8;
  localparam int BIW          = $clog2(BPW);
  localparam int WCW          = $clog2(WORD_COUNT) + 1;
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUDRATE;
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(BPW);
  localparam logic [WCW-1:0]        LAST_WORD = WCW'(WORD_COUNT - 1);
  localparam logic [BIW-1:0]        LAST_BYTE = BIW'(BPW - 1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk     (clk),
    .resetn  (resetn),
    .rx      (rx),
    .data_o  (rx_byte),
    .valid_o (rx_valid),
    .err_o   (rx_err)
  );

  ld_state_t             ld_q, ld_d;
  wr_state_t             wr_q, wr_d;
  logic [DATA_WIDTH-1:0] pack_q, pack_d, hold_q, hold_d, pack_word;
  logic [BIW-1:0]        bidx_q, bidx_d;
  logic                  hold_vld_q, hold_vld_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WCW-1:0]        wcnt_q, wcnt_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic [2:0]            err_q, err_d;
  logic                  resp_fire, last_resp;

  always_comb begin
    ld_d       = ld_q;
    wr_d       = wr_q;
    pack_d     = pack_q;
    bidx_d     = bidx_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    addr_d     = addr_q;
    wcnt_d     = wcnt_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    err_d      = err_q;
    pack_word  = pack_q;
    resp_fire  = (wr_q == W_RESP) && m_axil_bvalid;
    last_resp  = resp_fire && (wcnt_q == LAST_WORD);

    case (ld_q)
      IDLE, DONE: begin
        if (start) begin
          ld_d       = ACTIVE;
          err_d      = '0;
          addr_d     = BASE;
          wcnt_d     = '0;
          bidx_d     = '0;
          pack_d     = '0;
          hold_vld_d = 1'b0;
        end
      end
      ACTIVE:  if (last_resp) ld_d = DONE;
      default: ld_d = IDLE;
    endcase

    case (wr_q)
      W_IDLE: begin
        if (hold_vld_q && (ld_q == ACTIVE)) begin
          wr_d      = W_REQ;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end
      end
      W_REQ: begin
        if (m_axil_awready) awvalid_d = 1'b0;
        if (m_axil_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) wr_d = W_RESP;
      end
      W_RESP: begin
        if (m_axil_bvalid) begin
          wr_d       = W_IDLE;
          hold_vld_d = 1'b0;
          addr_d     = addr_q + STEP;
          wcnt_d     = wcnt_q + WCW'(1);
          if (m_axil_bresp != AXI_RESP_OKAY) err_d[ERR_BUS] = 1'b1;
        end
      end
      default: wr_d = W_IDLE;
    endcase

    // hold_vld_d already reflects a same-cycle response, so a word that
    // completes on the freeing cycle is accepted rather than dropped.
    if ((ld_q == ACTIVE) && !last_resp) begin
      if (rx_valid) begin
        pack_word[{bidx_q, 3'b000} +: 8] = rx_byte;
        if (bidx_q == LAST_BYTE) begin
          bidx_d = '0;
          pack_d = '0;
          if (!hold_vld_d) begin
            hold_d     = pack_word;
            hold_vld_d = 1'b1;
          end else begin
            err_d[ERR_OVR] = 1'b1;
          end
        end else begin
          pack_d = pack_word;
          bidx_d = bidx_q + BIW'(1);
        end
      end
      if (rx_err) err_d[ERR_RX] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ld_q       <= IDLE;
      wr_q       <= W_IDLE;
      pack_q     <= '0;
      bidx_q     <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      addr_q     <= BASE;
      wcnt_q     <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      err_q      <= '0;
    end else begin
      ld_q       <= ld_d;
      wr_q       <= wr_d;
      pack_q     <= pack_d;
      bidx_q     <= bidx_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      addr_q     <= addr_d;
      wcnt_q     <= wcnt_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      err_q      <= err_d;
    end
  end

  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = hold_q;
  assign m_axil_wstrb   = '1;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = (wr_q == W_RESP);
  assign busy           = (ld_q == ACTIVE);
  assign done           = (ld_q == DONE);
  assign err            = err_q;

endmodule
